// File: rtl/ksa_pkg.sv
`default_nettype none
// ============================================================================
// ksa_pkg : shared state encoding, default width and clog2 helper for the
//           sequenced Kogge-Stone adder controller.
// Revision: 1.0
// ============================================================================
package ksa_pkg;

  localparam int WIDTH_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PG     = 3'd1,
    PREFIX = 3'd2,
    SUM    = 3'd3,
    DONE   = 3'd4
  } ksa_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_prefix_row.sv
`default_nettype none
// ============================================================================
// ksa_prefix_row : one reusable row of Kogge-Stone prefix cells; span 2^k.
// Revision: 1.0
// ============================================================================
module ksa_prefix_row #(
  parameter int WIDTH  = 64,
  parameter int LEVELS = 6,
  parameter int KW     = 3
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] g_o
);

  logic [LEVELS-1:0] span;
  logic [WIDTH-1:0]  p_sh;
  logic [WIDTH-1:0]  g_sh;
  logic [WIDTH-1:0]  low_mask;

  assign span     = LEVELS'(1) << k;
  assign p_sh     = p_i << span;
  assign g_sh     = g_i << span;
  assign low_mask = ~({WIDTH{1'b1}} << span);

  // Bits below the span have no partner cell and keep their P unchanged.
  assign g_o = g_i | (p_i & g_sh);
  assign p_o = (p_i & p_sh) | (p_i & low_mask);

endmodule
`default_nettype wire

// File: rtl/ksa_seq_ctrl.sv
`default_nettype none
// ============================================================================
// ksa_seq_ctrl : multi-cycle add/sub using one prefix row per level, with
//                Y86 flags. Option KSA_EARLY_EXIT_EN skips levels once P == 0.
// Revision: 1.0
// ============================================================================
module ksa_seq_ctrl
  import ksa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             busy
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int KW     = (LEVELS > 1) ? clog2(LEVELS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(LEVELS - 1);

  ksa_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hs_q, hs_d, p_q, p_d, g_q, g_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cin_q, cin_d;
  logic             cout_q, cout_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;

  logic [WIDTH-1:0] hs_pg, p_pg, g_pg;
  logic [WIDTH-1:0] p_nxt, g_nxt;
  logic [WIDTH-1:0] carry, sum_nxt;

  ksa_prefix_row #(
    .WIDTH  (WIDTH),
    .LEVELS (LEVELS),
    .KW     (KW)
  ) u_row (
    .p_i (p_q),
    .g_i (g_q),
    .k   (k_q),
    .p_o (p_nxt),
    .g_o (g_nxt)
  );

  // Carry-in is absorbed into bit 0 so the prefix tree needs no extra column.
  assign hs_pg   = a_q ^ b_q;
  assign g_pg    = {a_q[WIDTH-1:1] & b_q[WIDTH-1:1],
                    (a_q[0] & b_q[0]) | (hs_pg[0] & cin_q)};
  assign p_pg    = {hs_pg[WIDTH-1:1], 1'b0};
  assign carry   = {g_q[WIDTH-2:0], cin_q};
  assign sum_nxt = hs_q ^ carry;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    hs_d    = hs_q;
    p_d     = p_q;
    g_d     = g_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          cin_d   = op_sub;
          state_d = PG;
        end
      end
      PG: begin
        hs_d = hs_pg;
        p_d  = p_pg;
        g_d  = g_pg;
        k_d  = '0;
`ifdef KSA_EARLY_EXIT_EN
        state_d = (p_pg == '0) ? SUM : PREFIX;
`else
        state_d = PREFIX;
`endif
      end
      PREFIX: begin
        p_d = p_nxt;
        g_d = g_nxt;
        k_d = k_q + KW'(1);
`ifdef KSA_EARLY_EXIT_EN
        if ((k_q == K_LAST) || (p_nxt == '0)) state_d = SUM;
`else
        if (k_q == K_LAST) state_d = SUM;
`endif
      end
      SUM: begin
        sum_d   = sum_nxt;
        cout_d  = g_q[WIDTH-1];
        zf_d    = ~|sum_nxt;
        sf_d    = sum_nxt[WIDTH-1];
        of_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nxt[WIDTH-1] != a_q[WIDTH-1]);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      hs_q    <= '0;
      p_q     <= '0;
      g_q     <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      hs_q    <= hs_d;
      p_q     <= p_d;
      g_q     <= g_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule
`default_nettype wire

// File: doc/ksa_seq_ctrl.md
Name: ksa_seq_ctrl

Overview:
- Sequencing controller for the Kogge-Stone prefix adder in the ALU `add` logic.
- Computes a WIDTH-bit add/subtract over multiple cycles by reusing one row of prefix cells (black and yellow circles), one prefix level per cycle.
- Produces sum and Y86 condition flags (ZF, SF, OF) plus carry-out.
- Sits between the ALU op decoder and the CC register, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 64, operand width; must be a power of two, ≥ 2.
- LEVELS, $clog2(WIDTH), number of prefix levels. Derived; not to be overridden.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op valid
- in_ready  out  1  controller can accept; high only in IDLE
- op_sub  in  1  0 = A+B; 1 = A−B (B inverted, cin = 1)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid; held until taken
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (raw carry; no borrow inversion)
- zf  out  1  sum == 0
- sf  out  1  sum[WIDTH-1]
- of  out  1  signed overflow
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; in_ready = 1.
  - out_valid, busy, sum, cout, zf, sf, of all 0.
  - Internal P/G/half-sum registers cleared.
  - Reset mid-operation abandons the operation; no partial result is ever presented.
- States: IDLE, PG, PREFIX, SUM, DONE.
- IDLE:
  - in_valid && in_ready → latch a, b' = op_sub ? ~b : b, cin = op_sub.
  - Go to PG.
- PG (1 cycle):
  - Register hs = a ^ b'.
  - g[i] = a[i] & b'[i]; p[i] = hs[i].
  - cin is folded into bit 0: g[0] = a0&b'0 | hs0&cin, p[0] = 0.
  - Clear level counter k = 0.
  - Go to PREFIX.
- PREFIX (one cycle per level):
  - Span d = 2^k.
  - For i ≥ d, black cell: G[i] = G[i] | P[i]&G[i-d] and P[i] = P[i]&P[i-d].
  - For i < d: pass through (yellow cell on the G[i-d] boundary when i-d < 0 is not applied).
  - All bits update in the same cycle from the previous-level registers.
  - k increments; after k == LEVELS-1 go to SUM.
- SUM (1 cycle):
  - c[-1] = cin; c[i] = G[i].
  - sum[i] = hs[i] ^ c[i-1].
  - cout = G[WIDTH-1].
  - zf = ~|sum; sf = sum[MSB].
  - of = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
  - out_valid = 1; go to DONE.
- DONE:
  - Outputs held stable while out_ready is low.
  - out_valid && out_ready → out_valid = 0, go to IDLE.
  - in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency (baseline): accept edge → out_valid after LEVELS+2 rising edges (8 for WIDTH = 64). Throughput: one op per LEVELS+4 cycles minimum.
- in_valid while busy is ignored (in_ready = 0); the inputs are not sampled.
- Wrap-around: sum is modulo 2^WIDTH; cout carries the lost bit.

Optional Feature:
- Macro: KSA_EARLY_EXIT_EN.
- Defined:
  - At the end of PG and of every PREFIX level, if the entire group-propagate vector P is 0, jump directly to SUM.
  - This is valid because further levels cannot change G when P = 0.
  - Latency becomes variable, between 2 and LEVELS+2 edges.
- Undefined: fixed latency LEVELS+2, with no P-vector reduction logic.

Decomposition:
- Package ksa_pkg:
  - State enum ksa_state_t {IDLE, PG, PREFIX, SUM, DONE}.
  - Constant WIDTH_DEFAULT = 64.
  - Function clog2 helper for LEVELS.
- Sub-module ksa_prefix_row (combinational):
  - Inputs: P, G, level k.
  - Outputs: next-level P, G built from black/yellow cells with a shift-by-2^k mux.
  - Instantiated once in ksa_seq_ctrl.

Test Plan:
- Add, a=5, b=7, op_sub=0 → sum=12, cout=0, zf=0, sf=0, of=0; out_valid exactly 8 edges after accept (macro off).
- Sub, a=5, b=5 → sum=0, zf=1, cout=1, of=0.
- Signed overflow, a=0x7FFF_FFFF_FFFF_FFFF, b=1, add → sum=0x8000_0000_0000_0000, of=1, sf=1, cout=0.
- Full wrap, a=0xFFFF_FFFF_FFFF_FFFF, b=1, add → sum=0, cout=1, zf=1, of=0.
- Handshake: hold out_ready=0 for 5 cycles → sum/flags/out_valid stable; drive in_valid high throughout busy → no second accept. Assert rst_n=0 mid-PREFIX → all outputs 0 immediately, in_ready=1.
- KSA_EARLY_EXIT_EN defined, a=1, b=2 → sum=3 after 3 edges; a=0, b=0 → sum=0, zf=1 after 2 edges.
